spi_slave8r: RTL and testbench
==============================

// Module: spi_slave8r
// PURPOSE
//  3-wire half-duplex SPI target (responder) for the 7-bit-address / 8-bit-data register protocol issued by the ADC/PLL config master.
//  Used as the on-fabric register-file model of the ADC front-end: bench-side stand-in for the converter, and as the control-port target of the DA board.
//  Oversamples SCLK/CE in the system clock domain, decodes write/read frames, holds a register file and returns read data on spi_out.
// PARAMETERS
//  NREG         32     number of R/W registers at addresses 0..NREG-1 (1..128)
//  STATUS_ADDR  7'h18  read-only address returning status_in; writes to it are dropped
//  RST_VAL      8'h00  reset value of every R/W register
// PORTS
//  clk        in   1  system clock; must be >= 8x spi_sclk frequency
//  rst        in   1  synchronous, active-high reset
//  spi_ce     in   1  chip enable, active low; high aborts/ends a frame
//  spi_sclk   in   1  SPI clock, idle low; master shifts on fall, target samples on rise
//  spi_in     in   1  serial data from master (MOSI)
//  spi_out    out  1  serial data to master (MISO); 0 when not driving
//  spi_dir    out  1  1 = target drives the shared data line (read-data phase)
//  status_in  in   8  live status byte, sampled at the read-address boundary
//  wr_stb     out  1  1-clk pulse when a register write commits
//  wr_addr    out  7  address of committed write (valid with wr_stb)
//  wr_data    out  8  data of committed write (valid with wr_stb)
// BEHAVIOUR
//  Input sync: spi_ce, spi_sclk, spi_in through 2-FF sync; SCLK rise/fall = edge of synced copy; edge latency 3 clk.
//  Frame (MSB first): bit15 R/W (1=read), bits14:8 addr[6:0], bits7:0 data. Bit counter cnt 0..15, cleared while ce high.
//  FSM: IDLE -> CMD (ce falls) -> WDATA (R/W=0 after bit 8) or RDATA (R/W=1 after bit 8) -> DONE (cnt=16) -> IDLE (ce rises).
//  CMD: shift spi_in on each SCLK rise; on 8th rise latch rw, addr.
//  Read: at 8th rise latch rd byte = status_in if addr==STATUS_ADDR, reg[addr] if addr<NREG, else 8'h00.
//   spi_dir=1 from first SCLK fall after 8th rise until ce rises or DONE; spi_out = rd byte MSB first, next bit on each SCLK fall.
//  Write: shift 8 data bits; on 16th rise commit reg[addr] (if addr<NREG and addr!=STATUS_ADDR), pulse wr_stb 1 clk later for any addr.
//  ce rising before 16th rise: frame aborted, no commit, no wr_stb, spi_dir=0 same cycle ce-high is seen synced.
//  Extra SCLK edges in DONE ignored; spi_dir=0 in DONE.
//  Reset: state=IDLE, cnt=0, all regs=RST_VAL, spi_out=0, spi_dir=0, wr_stb=0, wr_addr=0, wr_data=0; reset mid-frame discards frame, next frame needs fresh ce fall.
//  SCLK edge and ce rise in same cycle: ce rise wins (abort).
// CONFIGURATION
//  SPI_STREAM_EN defined: after byte 1, further 8-bit groups in the same frame continue to addr+1 (7-bit wrap 7'h7F->7'h00);
//   each write group commits + pulses wr_stb on its 8th rise; reads reload rd byte at each group boundary.
//  SPI_STREAM_EN undefined: one data byte per frame; DONE after 16 bits as above.
// TESTING
//  Write 0x05<=0xA5, then read 0x05 -> wr_stb once with addr 0x05/data 0xA5; readback shifts 1010_0101, spi_dir high only for 8 bits.
//  status_in=0x07, read 0x18 -> 0x07 returned; write 0x18<=0x00 -> wr_stb pulses, later read still returns status_in.
//  Read addr 0x7F with NREG=32 -> 0x00 returned; write 0x7F<=0x55 -> reg file unchanged, wr_stb with addr 0x7F.
//  Write 0x02<=0xFF, ce high after 12 bits -> reg 0x02 keeps RST_VAL, no wr_stb, spi_dir=0.
//  rst pulse mid-read of 0x05 -> spi_dir=0, regs=RST_VAL; next full read of 0x05 returns 0x00.
//  SPI_STREAM_EN: write frame at 0x7F with bytes 0x11,0x22 -> wr_stb for 0x7F then 0x00; reg[0]=0x22.

Source files
------------

// File: rtl/spi_slave8r_if.sv
// Bus bundle for the spi_slave8r register target: 3-wire SPI pins, live status
// byte and the committed-write report.
interface spi_slave8r_if;
  logic       spi_ce;
  logic       spi_sclk;
  logic       spi_in;
  logic       spi_out;
  logic       spi_dir;
  logic [7:0] status_in;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output spi_ce, spi_sclk, spi_in, status_in,
    input  spi_out, spi_dir, wr_stb, wr_addr, wr_data
  );

  modport slave (
    input  spi_ce, spi_sclk, spi_in, status_in,
    output spi_out, spi_dir, wr_stb, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_slave8r.sv
// 3-wire SPI register-file target, 7-bit address / 8-bit data, oversampled in clk.
// Define SPI_STREAM_EN to let a frame continue with further data bytes at addr+1.
module spi_slave8r #(
  parameter int         NREG        = 32,
  parameter logic [6:0] STATUS_ADDR = 7'h18,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input logic           clk,
  input logic           rst,
  spi_slave8r_if.slave  bus
);

  localparam int         AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [7:0] NREG_W = 8'(NREG);
`ifdef SPI_STREAM_EN
  localparam logic       STREAM = 1'b1;
`else
  localparam logic       STREAM = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [1:0]  r_ce_sync;
  logic [1:0]  r_sclk_sync;
  logic [1:0]  r_in_sync;
  logic        r_ce_d;
  logic        r_sclk_d;
  logic [3:0]  r_cnt;
  logic [6:0]  r_shift;
  logic [6:0]  r_addr;
  logic [7:0]  r_rd;
  logic [7:0]  r_regs [2**AW];
  logic        r_out;
  logic        r_dir;
  logic        r_wr_pend;
  logic        r_wr_stb;
  logic [6:0]  r_wr_addr;
  logic [7:0]  r_wr_data;

  logic        w_ce_high;
  logic        w_ce_fall;
  logic        w_rise;
  logic        w_fall;
  logic        w_bit;
  logic        w_in_frame;
  logic        w_cmd_last;
  logic        w_data_last;
  logic [6:0]  w_cmd_addr;
  logic [7:0]  w_byte;
  logic        w_wr_ok;
  logic [6:0]  w_look_addr;
  logic [7:0]  w_look_byte;

  // Reset clears the chip-enable history to "low" so a frame in flight at reset
  // cannot be picked up halfway: only a genuine high-to-low ce starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_sync   <= 2'b00;
      r_sclk_sync <= 2'b00;
      r_in_sync   <= 2'b00;
      r_ce_d      <= 1'b0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ce_sync   <= {r_ce_sync[0], bus.spi_ce};
      r_sclk_sync <= {r_sclk_sync[0], bus.spi_sclk};
      r_in_sync   <= {r_in_sync[0], bus.spi_in};
      r_ce_d      <= r_ce_sync[1];
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  assign w_ce_high   = r_ce_sync[1];
  assign w_ce_fall   = r_ce_d & ~r_ce_sync[1];
  assign w_rise      = r_sclk_sync[1] & ~r_sclk_d;
  assign w_fall      = ~r_sclk_sync[1] & r_sclk_d;
  assign w_bit       = r_in_sync[1];
  assign w_in_frame  = (r_state == S_CMD) || (r_state == S_WDATA) || (r_state == S_RDATA);
  assign w_cmd_last  = w_rise && (r_state == S_CMD) && (r_cnt == 4'd7);
  assign w_data_last = w_rise && ((r_state == S_WDATA) || (r_state == S_RDATA)) && (r_cnt == 4'd15);
  assign w_cmd_addr  = {r_shift[5:0], w_bit};
  assign w_byte      = {r_shift, w_bit};
  assign w_wr_ok     = (r_addr != STATUS_ADDR) && ({1'b0, r_addr} < NREG_W);

  // Read-byte source: command address at the 8th rise, next address at stream boundaries
  always_comb begin
    w_look_addr = (r_state == S_CMD) ? w_cmd_addr : (r_addr + 7'd1);
    if (w_look_addr == STATUS_ADDR) begin
      w_look_byte = bus.status_in;
    end else if ({1'b0, w_look_addr} < NREG_W) begin
      w_look_byte = r_regs[w_look_addr[AW-1:0]];
    end else begin
      w_look_byte = 8'h00;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; a synced-high ce overrides any same-cycle SCLK edge
  always_comb begin
    w_state_nx = r_state;
    if (w_ce_high) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ce_fall) w_state_nx = S_CMD;
          else           w_state_nx = S_IDLE;
        end
        S_CMD: begin
          if (w_cmd_last) w_state_nx = r_shift[6] ? S_RDATA : S_WDATA;
          else            w_state_nx = S_CMD;
        end
        S_WDATA, S_RDATA: begin
          if (w_data_last && !STREAM) w_state_nx = S_DONE;
          else                        w_state_nx = r_state;
        end
        S_DONE:  w_state_nx = S_DONE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Shift/count, register file, read-data serializer and write report
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_shift   <= 7'd0;
      r_addr    <= 7'd0;
      r_rd      <= 8'h00;
      r_out     <= 1'b0;
      r_dir     <= 1'b0;
      r_wr_pend <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 7'd0;
      r_wr_data <= 8'h00;
      for (int i = 0; i < 2**AW; i++) begin
        r_regs[i] <= RST_VAL;
      end
    end else begin
      r_wr_stb  <= r_wr_pend;
      r_wr_pend <= 1'b0;
      if (w_ce_high || (r_state == S_IDLE)) begin
        r_cnt <= 4'd0;
        r_dir <= 1'b0;
        r_out <= 1'b0;
      end else if (w_in_frame && w_rise) begin
        r_shift <= w_cmd_addr;
        r_cnt   <= r_cnt + 4'd1;
        if (w_cmd_last) begin
          r_addr <= w_cmd_addr;
          r_rd   <= w_look_byte;
        end
        if (w_data_last && (r_state == S_WDATA)) begin
          if (w_wr_ok) r_regs[r_addr[AW-1:0]] <= w_byte;
          r_wr_pend <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= w_byte;
          if (STREAM) begin
            r_addr <= r_addr + 7'd1;
            r_cnt  <= 4'd8;
          end
        end
        if (w_data_last && (r_state == S_RDATA)) begin
          if (STREAM) begin
            r_addr <= r_addr + 7'd1;
            r_rd   <= w_look_byte;
            r_cnt  <= 4'd8;
          end else begin
            r_dir <= 1'b0;
            r_out <= 1'b0;
          end
        end
      end else if ((r_state == S_RDATA) && w_fall) begin
        r_dir <= 1'b1;
        r_out <= r_rd[7];
        r_rd  <= {r_rd[6:0], 1'b0};
      end
    end
  end

  assign bus.spi_out = r_out;
  assign bus.spi_dir = r_dir;
  assign bus.wr_stb  = r_wr_stb;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule

// File: tb/tb_spi_slave8r.sv
// Randomized frame-level bench for spi_slave8r against a register-file model.
`timescale 1ns/1ps
module tb_spi_slave8r;

  localparam int         NREG        = 32;
  localparam logic [6:0] STATUS_ADDR = 7'h18;
  localparam logic [7:0] RST_VAL     = 8'h00;
  localparam int         HALF        = 6;
`ifdef SPI_STREAM_EN
  localparam bit         STREAM      = 1'b1;
`else
  localparam bit         STREAM      = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_slave8r_if bus();

  spi_slave8r #(
    .NREG        (NREG),
    .STATUS_ADDR (STATUS_ADDR),
    .RST_VAL     (RST_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model_regs [128];
  logic [7:0]  cur_status;
  logic [14:0] wr_obs [$];

  // Every wr_stb-high cycle is logged, so a stretched pulse shows up as an extra entry
  always @(negedge clk) begin
    if (bus.wr_stb === 1'b1) wr_obs.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == STATUS_ADDR)  return cur_status;
    else if (int'(a) < NREG) return model_regs[a];
    else                   return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model_regs[i] = RST_VAL;
  endtask

  // One master frame of nbits SCLK pulses; rst_at > 0 pulses rst after that rise
  task automatic do_frame(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                          input int nbits, input int rst_at);
    logic [31:0] exp_dir;
    logic [31:0] exp_out;
    logic [31:0] obs_dir;
    logic [31:0] obs_out;
    logic [14:0] exp_wr [$];
    logic        exp_end_dir;
    int          n_grp;
    exp_dir = 32'd0;
    exp_out = 32'd0;
    obs_dir = 32'd0;
    obs_out = 32'd0;
    for (int i = 9; i <= nbits; i++) begin
      if (rw && (STREAM || i <= 16) && (rst_at == 0 || i <= rst_at)) begin
        logic [7:0] b;
        b = model_read(addr + 7'((i - 9) / 8));
        exp_dir[i-1] = 1'b1;
        exp_out[i-1] = b[7 - ((i - 9) % 8)];
      end
    end
    exp_end_dir = rw && (nbits >= 8) && (STREAM || nbits < 16) && (rst_at == 0);
    n_grp = (nbits >= 16) ? (STREAM ? (nbits - 8) / 8 : 1) : 0;
    if (!rw) begin
      for (int g = 0; g < n_grp; g++) begin
        logic [6:0] a;
        logic [7:0] d;
        a = addr + 7'(g);
        d = data[31 - 8*g -: 8];
        exp_wr.push_back({a, d});
        if (a != STATUS_ADDR && int'(a) < NREG) model_regs[a] = d;
      end
    end
    wr_obs.delete();

    @(negedge clk);
    bus.spi_ce   = 1'b0;
    bus.spi_sclk = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 1; i <= nbits; i++) begin
      if (i == 1)      bus.spi_in = rw;
      else if (i <= 8) bus.spi_in = addr[8 - i];
      else             bus.spi_in = rw ? 1'b0 : data[31 - (i - 9)];
      repeat (HALF) @(negedge clk);
      obs_dir[i-1] = bus.spi_dir;
      obs_out[i-1] = bus.spi_out;
      bus.spi_sclk = 1'b1;
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dir", {31'd0, bus.spi_dir}, 32'd0);
        rst = 1'b0;
        model_reset();
      end
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    chk("end_dir", {31'd0, bus.spi_dir}, {31'd0, exp_end_dir});
    bus.spi_ce = 1'b1;
    repeat (8) @(negedge clk);
    chk("dir_vec", obs_dir, exp_dir);
    chk("miso_vec", obs_out, exp_out);
    chk("idle_dir", {31'd0, bus.spi_dir}, 32'd0);
    chk("idle_out", {31'd0, bus.spi_out}, 32'd0);
    chk("wr_count", 32'(wr_obs.size()), 32'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size(); k++) begin
      chk("wr_entry", (k < wr_obs.size()) ? 32'(wr_obs[k]) : 32'hFFFF_FFFF, 32'(exp_wr[k]));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ra;
    int         nb;
    bus.spi_ce    = 1'b1;
    bus.spi_sclk  = 1'b0;
    bus.spi_in    = 1'b0;
    cur_status    = 8'h00;
    bus.status_in = cur_status;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dir", {31'd0, bus.spi_dir}, 32'd0);
    chk("rst_out", {31'd0, bus.spi_out}, 32'd0);
    chk("rst_wr_stb", {31'd0, bus.wr_stb}, 32'd0);
    chk("rst_wr_addr", {25'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_frame(1'b0, 7'h05, 32'hA500_0000, 16, 0);
    do_frame(1'b1, 7'h05, 32'h0, 16, 0);
    cur_status = 8'h07;
    bus.status_in = cur_status;
    do_frame(1'b1, STATUS_ADDR, 32'h0, 16, 0);
    do_frame(1'b0, STATUS_ADDR, 32'h0000_0000, 16, 0);
    cur_status = 8'h3C;
    bus.status_in = cur_status;
    do_frame(1'b1, STATUS_ADDR, 32'h0, 16, 0);
    do_frame(1'b1, 7'h7F, 32'h0, 16, 0);
    do_frame(1'b0, 7'h7F, 32'h5500_0000, 16, 0);
    do_frame(1'b1, 7'h05, 32'h0, 16, 0);
    do_frame(1'b0, 7'h02, 32'hFF00_0000, 12, 0);
    do_frame(1'b1, 7'h02, 32'h0, 16, 0);
    do_frame(1'b1, 7'h05, 32'h0, 16, 12);
    do_frame(1'b1, 7'h05, 32'h0, 16, 0);
    do_frame(1'b0, 7'h03, 32'h5A_C3_96_00, 24, 0);
    do_frame(1'b1, 7'h03, 32'h0, 24, 0);
`ifdef SPI_STREAM_EN
    do_frame(1'b0, 7'h7F, 32'h1122_0000, 24, 0);
    do_frame(1'b1, 7'h00, 32'h0, 16, 0);
    do_frame(1'b1, 7'h7F, 32'h0, 32, 0);
`endif

    for (int n = 0; n < 45; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = 7'h7F;
        1:       ra = STATUS_ADDR;
        2:       ra = 7'($urandom);
        default: ra = 7'($urandom_range(0, NREG - 1));
      endcase
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, STREAM ? 32 : 24);
      else                           nb = STREAM ? 8 * $urandom_range(2, 4) : 16;
      cur_status = 8'($urandom);
      bus.status_in = cur_status;
      do_frame(1'($urandom), ra, $urandom, nb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
